rgmii_rx_assembler: RTL
=======================

RGMII_RX_ASSEMBLER -- requirements
Module: rgmii_rx_assembler

Downstream of the input DDR stage. Converts RGMII nibble pairs into a GMII byte stream with a byte strobe. Decodes RX_ER and in-band link status.

Interface
REQ-001 Parameter STATUS_FILTER, default 2: number of consecutive identical idle status samples required before the status outputs update; legal range 1..15.
REQ-002 clk  input  1  receive clock (RGMII RXC domain); all logic on posedge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 rxd_q1  input  4  nibble captured on the rising edge, from the DDR stage q1.
REQ-005 rxd_q2  input  4  nibble captured on the falling edge, from the DDR stage q2.
REQ-006 rx_ctl_q1  input  1  RX_CTL rising-edge sample (RX_DV).
REQ-007 rx_ctl_q2  input  1  RX_CTL falling-edge sample (RX_DV xor RX_ER).
REQ-008 speed  input  2  link speed: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10; 2'b11 is treated as 1000.
REQ-009 gmii_rxd  output  8  assembled byte.
REQ-010 gmii_rx_dv  output  1  data valid, qualified by gmii_rx_valid.
REQ-011 gmii_rx_er  output  1  receive error, qualified by gmii_rx_valid.
REQ-012 gmii_rx_valid  output  1  one-cycle strobe marking a new byte on gmii_rxd/dv/er.
REQ-013 link_up  output  1  in-band link status.
REQ-014 link_speed  output  2  in-band speed, same encoding as speed.
REQ-015 full_duplex  output  1  in-band duplex status.

Function
REQ-016 Decoding per cycle: dv_i = rx_ctl_q1; er_i = rx_ctl_q1 ^ rx_ctl_q2.
REQ-017 1000 mode, every cycle, with 1-cycle registered latency:
- gmii_rxd = {rxd_q2, rxd_q1}
- gmii_rx_dv = dv_i
- gmii_rx_er = er_i
- gmii_rx_valid = 1
REQ-018 10/100 mode uses only rxd_q1 (SDR). The nibble state machine has three states: IDLE, LOW (low nibble held), HIGH.
REQ-019 State transitions:
- IDLE: dv_i=1 stores rxd_q1 as the low nibble and moves to LOW; dv_i=0 stays in IDLE.
- LOW: dv_i=1 emits {rxd_q1, held} with dv=1, er = er_i OR the held er, valid=1, and moves to HIGH.
- HIGH: dv_i=1 stores a new low nibble and moves to LOW; dv_i=0 moves to IDLE with no strobe.
REQ-020 10/100 output latency is 1 cycle after the high nibble is sampled.
REQ-021 Odd-nibble termination: if dv_i=0 while in LOW, emit {4'h0, held} with dv=1, er=1, valid=1, then go to IDLE.
REQ-022 10/100 idle with er_i=1 (carrier extension or false carrier): emit {rxd_q1, rxd_q1}, dv=0, er=1, valid=1 on every second cycle while er_i stays asserted.
REQ-023 10/100 idle with dv_i=0 and er_i=0: gmii_rx_valid=0.
REQ-024 speed is sampled only while no frame is in progress (1000 mode dv_i=0, or 10/100 state IDLE). A change mid-frame takes effect on the first idle cycle after the frame.
REQ-025 gmii_rx_valid is never high for two consecutive cycles in 10/100 mode.

Reset
REQ-026 While rst is asserted, all outputs are 0 immediately, independent of clk:
- gmii_rxd=8'h00, dv=0, er=0, valid=0
- link_up=0, link_speed=2'b00, full_duplex=0
REQ-027 Reset also clears the state machine to IDLE, the held nibble, the latched speed and the status filter counter.
REQ-028 Reset asserted mid-frame discards the partial byte; no strobe is emitted on release.
REQ-029 The first byte after reset release is emitted only after a fresh dv_i rising edge.

Configuration
REQ-030 Macro RGMII_RX_INBAND_STATUS_EN defined: the status decoder is compiled in.
- Each cycle with dv_i=0 and er_i=0 samples rxd_q1: bit0 = link, bits2:1 = speed, bit3 = duplex.
- The filter counter counts consecutive identical samples.
- When the count reaches STATUS_FILTER, the sample is latched to link_up/link_speed/full_duplex.
- Any differing sample or any data cycle clears the counter.
REQ-031 Macro not defined: link_up, link_speed and full_duplex are tied to 0, and no filter logic is present.

Verification
REQ-032 1000 mode; q1=4'h5, q2=4'hD, ctl_q1=1, ctl_q2=1 -> next cycle gmii_rxd=8'hD5, dv=1, er=0, valid=1.
REQ-033 100 mode; 4-cycle burst of rxd_q1 = 5,5,D,5 with dv_i=1 -> two strobes, bytes 8'h55 then 8'h5D, strobes 2 cycles apart, dv=1, er=0.
REQ-034 10 mode; 3 nibbles 1,2,3 then dv_i=0 -> strobes carry 8'h21 (er=0) then 8'h03 (dv=1, er=1); state returns to IDLE.
REQ-035 1000 mode frame with speed switched to 2'b01 mid-frame -> remaining bytes still assembled as gigabit; 10/100 assembly starts at the next frame.
REQ-036 Macro defined, STATUS_FILTER=2; idle rxd_q1=4'hD for 2 cycles -> link_up=1, link_speed=2'b10, full_duplex=1; a single 4'h0 glitch leaves the outputs unchanged.
REQ-037 rst pulsed while in LOW state -> outputs 0 asynchronously; no strobe after release until a new dv_i rising edge.

Source files
------------

// File: rtl/rgmii_rx_assembler.sv
// RGMII receive assembler: turns DDR nibble pairs (1000) or SDR nibbles (10/100) into a GMII byte stream with a strobe.
// Optional in-band link status decoder, compiled in when RGMII_RX_INBAND_STATUS_EN is defined.
module rgmii_rx_assembler #(
  parameter int STATUS_FILTER = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       rx_ctl_q1,
  input  logic       rx_ctl_q2,
  input  logic [1:0] speed,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_valid,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  // state  | meaning
  // S_IDLE | no 10/100 frame in progress
  // S_LOW  | low nibble held, waiting for the high nibble
  // S_HIGH | byte just emitted, next nibble starts a new byte
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t     state_q, state_d;
  logic [3:0] held_q, held_d;
  logic       held_er_q, held_er_d;
  logic [1:0] speed_q, speed_d;
  logic       armed_q, armed_d;
  logic [7:0] rxd_q, rxd_d;
  logic       dv_q, dv_d;
  logic       er_q, er_d;
  logic       valid_q, valid_d;

  logic       dv_i, er_i;
  logic       in_frame, blocked;
  logic [1:0] eff_speed;

  assign dv_i = rx_ctl_q1;
  assign er_i = rx_ctl_q1 ^ rx_ctl_q2;

  // speed only follows the input between frames; mid-frame the latched value rules
  assign in_frame  = speed_q[1] ? dv_i : (state_q != S_IDLE);
  assign eff_speed = in_frame ? speed_q : speed;
  // after reset, a frame already in flight is ignored until dv drops
  assign blocked   = !armed_q && dv_i;

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    held_er_d = held_er_q;
    speed_d   = eff_speed;
    armed_d   = armed_q | ~dv_i;
    rxd_d     = rxd_q;
    dv_d      = dv_q;
    er_d      = er_q;
    valid_d   = 1'b0;

    if (blocked) begin
      state_d = S_IDLE;
    end else if (eff_speed[1]) begin
      rxd_d   = {rxd_q2, rxd_q1};
      dv_d    = dv_i;
      er_d    = er_i;
      valid_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dv_i) begin
            held_d    = rxd_q1;
            held_er_d = er_i;
            state_d   = S_LOW;
          end else if (er_i && !valid_q) begin
            // idle error: strobe every other cycle so valid never runs back to back
            rxd_d   = {rxd_q1, rxd_q1};
            dv_d    = 1'b0;
            er_d    = 1'b1;
            valid_d = 1'b1;
          end
        end
        S_LOW: begin
          if (dv_i) begin
            rxd_d   = {rxd_q1, held_q};
            dv_d    = 1'b1;
            er_d    = er_i | held_er_q;
            valid_d = 1'b1;
            state_d = S_HIGH;
          end else begin
            rxd_d   = {4'h0, held_q};
            dv_d    = 1'b1;
            er_d    = 1'b1;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_HIGH: begin
          if (dv_i) begin
            held_d    = rxd_q1;
            held_er_d = er_i;
            state_d   = S_LOW;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      held_q    <= 4'h0;
      held_er_q <= 1'b0;
      speed_q   <= 2'b00;
      armed_q   <= 1'b0;
      rxd_q     <= 8'h00;
      dv_q      <= 1'b0;
      er_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      held_er_q <= held_er_d;
      speed_q   <= speed_d;
      armed_q   <= armed_d;
      rxd_q     <= rxd_d;
      dv_q      <= dv_d;
      er_q      <= er_d;
      valid_q   <= valid_d;
    end
  end

  assign gmii_rxd      = rxd_q;
  assign gmii_rx_dv    = dv_q;
  assign gmii_rx_er    = er_q;
  assign gmii_rx_valid = valid_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  localparam logic [3:0] FILT = 4'(STATUS_FILTER);

  logic [3:0] stat_cnt_q, stat_cnt_d;
  logic [3:0] stat_last_q, stat_last_d;
  logic [3:0] stat_q, stat_d;
  logic       idle_s;

  assign idle_s = !dv_i && !er_i;

  always_comb begin
    stat_cnt_d  = stat_cnt_q;
    stat_last_d = stat_last_q;
    stat_d      = stat_q;
    if (!idle_s) begin
      stat_cnt_d = 4'd0;
    end else begin
      stat_last_d = rxd_q1;
      if (stat_cnt_q != 4'd0 && rxd_q1 == stat_last_q) begin
        if (stat_cnt_q != FILT) stat_cnt_d = stat_cnt_q + 4'd1;
      end else begin
        stat_cnt_d = 4'd1;
      end
      if (stat_cnt_d == FILT) stat_d = rxd_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt_q  <= 4'd0;
      stat_last_q <= 4'h0;
      stat_q      <= 4'h0;
    end else begin
      stat_cnt_q  <= stat_cnt_d;
      stat_last_q <= stat_last_d;
      stat_q      <= stat_d;
    end
  end

  // status nibble layout: {duplex, speed[1:0], link}
  assign link_up     = stat_q[0];
  assign link_speed  = stat_q[2:1];
  assign full_duplex = stat_q[3];
`else
  assign link_up     = 1'b0;
  assign link_speed  = 2'b00;
  assign full_duplex = 1'b0;
`endif

endmodule
